// File: rtl/div_radix_seq.sv
// Multi-cycle restoring integer divider retiring BPC quotient bits per cycle.
// Result packs {remainder, quotient}; supports signed/unsigned, annul and divide-by-zero flag.
module div_radix_seq #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_zero_o
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] ON     = 2'd2;
    localparam logic [1:0] END    = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quoReg;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   partRem;
    logic [WIDTH-1:0] divisorMag;
    logic             negQuo;
    logic             negRem;

    logic             accept;
    logic [WIDTH-1:0] dividendAbs;
    logic [WIDTH-1:0] divisorAbs;
    logic [WIDTH:0]   stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic [WIDTH-1:0] quoFinal;
    logic [WIDTH-1:0] remFinal;

    assign accept  = (state == IDLE) && start_i && !annul_i;
    assign ready_o = (state == END);
    assign busy_o  = (state == ON) || (state == BYZERO);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no latch is inferred.
        dividendAbs = opdata1_i;
        divisorAbs  = opdata2_i;
        if (signed_div_i && opdata1_i[WIDTH-1]) dividendAbs = -opdata1_i;
        if (signed_div_i && opdata2_i[WIDTH-1]) divisorAbs  = -opdata2_i;
    end

    // BPC unrolled restoring steps; the partial remainder stays below 2*divisor, so WIDTH+1 bits suffice.
    always_comb begin
        // NOTE: blocking assignments here chain the unrolled steps within one cycle; state regs use <=.
        stepRem = partRem;
        stepQuo = quoReg;
        for (int i = 0; i < BPC; i++) begin
            stepRem = {stepRem[WIDTH-1:0], stepQuo[WIDTH-1]};
            stepQuo = {stepQuo[WIDTH-2:0], 1'b0};
            if (stepRem >= {1'b0, divisorMag}) begin
                stepRem    = stepRem - {1'b0, divisorMag};
                stepQuo[0] = 1'b1;
            end
        end
        quoFinal = negQuo ? -stepQuo : stepQuo;
        remFinal = negRem ? -stepRem[WIDTH-1:0] : stepRem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_zero_o <= 1'b0;
                        count      <= '0;
                        state      <= (opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        state      <= END;
                        result_o   <= '0;
                        div_zero_o <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (count == LAST_COUNT) begin
                            state    <= END;
                            result_o <= {remFinal, quoFinal};
                        end
                    end
                end
                END: begin
                    if (!start_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: working registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            quoReg     <= dividendAbs;
            partRem    <= '0;
            divisorMag <= divisorAbs;
            negQuo     <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            negRem     <= signed_div_i && opdata1_i[WIDTH-1];
        end else if (state == ON) begin
            quoReg  <= stepQuo;
            partRem <= stepRem;
        end
    end

endmodule

// File: tb/tb_div_radix_seq.sv
// Self-checking bench for div_radix_seq: one BPC=1 and one BPC=4 instance, directed scenarios
// plus randomized operations checked against plain-arithmetic reference division.
module tb_div_radix_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signedDiv;
    logic        start;
    logic        annul;
    logic [31:0] opA;
    logic [31:0] opB;
    int          sel = 0;

    logic        start1, start4, annul1, annul4;
    logic [63:0] result1, result4;
    logic        ready1, ready4, busy1, busy4, dz1, dz4;

    logic [63:0] result;
    logic        ready, busy, divZero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign start1  = start & (sel == 0);
    assign annul1  = annul & (sel == 0);
    assign start4  = start & (sel == 1);
    assign annul4  = annul & (sel == 1);
    assign result  = (sel == 0) ? result1 : result4;
    assign ready   = (sel == 0) ? ready1  : ready4;
    assign busy    = (sel == 0) ? busy1   : busy4;
    assign divZero = (sel == 0) ? dz1     : dz4;

    div_radix_seq #(.WIDTH(32), .BPC(1)) dut1 (
        .clk(clk), .rst(rst), .signed_div_i(signedDiv),
        .opdata1_i(opA), .opdata2_i(opB), .start_i(start1), .annul_i(annul1),
        .result_o(result1), .ready_o(ready1), .busy_o(busy1), .div_zero_o(dz1)
    );

    div_radix_seq #(.WIDTH(32), .BPC(4)) dut4 (
        .clk(clk), .rst(rst), .signed_div_i(signedDiv),
        .opdata1_i(opA), .opdata2_i(opB), .start_i(start4), .annul_i(annul4),
        .result_o(result4), .ready_o(ready4), .busy_o(busy4), .div_zero_o(dz4)
    );

    // Reference: C-style truncating division on 64-bit integers; remainder follows dividend sign.
    task automatic refModel(input bit sg, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint na, nb, nq, nr;
        if (b == 32'd0) begin
            q = '0; r = '0; dz = 1'b1;
        end else begin
            if (sg) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            nq = na / nb;
            nr = na % nb;
            q  = nq[31:0];
            r  = nr[31:0];
            dz = 1'b0;
        end
    endtask

    // Issues one request on the selected instance and holds start until ready, then releases.
    // edges = rising edges after the accept edge until ready_o is seen (100 means it never came).
    task automatic doOp(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output logic dzAtAccept, output int edges, output int busyCycles);
        @(negedge clk);
        signedDiv = sg; opA = a; opB = b; start = 1'b1;
        @(posedge clk); #1;
        dzAtAccept = divZero;
        edges = 0;
        busyCycles = 0;
        while (ready !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busyCycles++;
            @(posedge clk); #1;
            edges++;
        end
        q  = result[31:0];
        r  = result[63:32];
        dz = divZero;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signedDiv = 1'b0; opA = '0; opB = '0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        if (result1 !== 64'd0) begin errors++; $display("FAIL reset_result1: got %h want 0", result1); end
        checks++;
        if (ready1 !== 1'b0 || busy1 !== 1'b0 || dz1 !== 1'b0) begin
            errors++; $display("FAIL reset_flags1: ready=%b busy=%b dz=%b want 000", ready1, busy1, dz1);
        end
        checks++;
        if (result4 !== 64'd0) begin errors++; $display("FAIL reset_result4: got %h want 0", result4); end
        checks++;
        if (ready4 !== 1'b0 || busy4 !== 1'b0 || dz4 !== 1'b0) begin
            errors++; $display("FAIL reset_flags4: ready=%b busy=%b dz=%b want 000", ready4, busy4, dz4);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; logic dz, dzA; int edges, busyCycles;
        sel = 0;
        doOp(1'b0, 32'd100, 32'd7, q, r, dz, dzA, edges, busyCycles);
        if (q !== 32'd14) begin errors++; $display("FAIL t1_quotient: got %0d want 14", q); end
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL t1_remainder: got %0d want 2", r); end
        checks++;
        if (edges !== 32) begin errors++; $display("FAIL t1_latency: ready after %0d edges want 32", edges); end
        checks++;
        if (busyCycles !== 32) begin errors++; $display("FAIL t1_busy: busy %0d cycles want 32", busyCycles); end
        checks++;
        if (dz !== 1'b0) begin errors++; $display("FAIL t1_divzero: got %b want 0", dz); end
        checks++;
    endtask

    task automatic test_signed();
        bit          sgs [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'd2, 32'hFFFF_FFFE, 32'h10};
        logic [31:0] qs  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0FFF_FFFF};
        logic [31:0] rs  [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_000F};
        logic [31:0] q, r; logic dz, dzA; int edges, busyCycles;
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            doOp(sgs[i], as[i], bs[i], q, r, dz, dzA, edges, busyCycles);
            if (q !== qs[i] || r !== rs[i]) begin
                errors++;
                $display("FAIL t2_case%0d: got Q=%h R=%h want Q=%h R=%h", i, q, r, qs[i], rs[i]);
            end
            checks++;
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; logic dz, dzA; int edges, busyCycles;
        sel = 0;
        doOp(1'b0, 32'd5, 32'd0, q, r, dz, dzA, edges, busyCycles);
        if (edges !== 1) begin errors++; $display("FAIL t3_latency: ready after %0d edges want 1", edges); end
        checks++;
        if ({r, q} !== 64'd0 || dz !== 1'b1) begin
            errors++; $display("FAIL t3_result: got %h dz=%b want 0 dz=1", {r, q}, dz);
        end
        checks++;
        doOp(1'b0, 32'd9, 32'd3, q, r, dz, dzA, edges, busyCycles);
        if (dzA !== 1'b0) begin errors++; $display("FAIL t3_clear_on_accept: got %b want 0", dzA); end
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0) begin
            errors++; $display("FAIL t3_followup: got Q=%0d R=%0d dz=%b want 3 0 0", q, r, dz);
        end
        checks++;
    endtask

    task automatic test_annul();
        logic [63:0] prior = {32'd0, 32'd3};
        bit sawReady;
        sel = 0;
        @(negedge clk);
        signedDiv = 1'b0; opA = 32'd1000; opB = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL t4_annul_state: busy=%b ready=%b want 0 0", busy, ready);
        end
        checks++;
        if (result !== prior) begin errors++; $display("FAIL t4_annul_result: got %h want %h", result, prior); end
        checks++;
        @(negedge clk);
        annul = 1'b0;
        sawReady = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready === 1'b1) sawReady = 1'b1;
        end
        if (sawReady) begin errors++; $display("FAIL t4_annul_noready: ready seen 1 want 0"); end
        checks++;
        @(negedge clk);
        opA = 32'd77; opB = 32'd5; start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        if (result !== 64'd0 || ready !== 1'b0 || busy !== 1'b0 || divZero !== 1'b0) begin
            errors++;
            $display("FAIL t4_reset_midop: result=%h ready=%b busy=%b dz=%b want all 0", result, ready, busy, divZero);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hold();
        logic [63:0] held;
        int edges;
        sel = 0;
        @(negedge clk);
        signedDiv = 1'b0; opA = 32'd20; opB = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (edges !== 32) begin errors++; $display("FAIL t5_latency: ready after %0d edges want 32", edges); end
        checks++;
        held = result;
        if (held !== {32'd0, 32'd5}) begin errors++; $display("FAIL t5_result: got %h want %h", held, {32'd0, 32'd5}); end
        checks++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opA = $urandom; opB = $urandom | 32'd1;
            @(posedge clk); #1;
            if (ready !== 1'b1 || busy !== 1'b0 || result !== held) begin
                errors++;
                $display("FAIL t5_hold%0d: ready=%b busy=%b result=%h want 1 0 %h", i, ready, busy, result, held);
            end
            checks++;
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t5_drop: ready=%b busy=%b want 0 0", ready, busy);
        end
        checks++;
        @(negedge clk);
        opA = 32'd50; opB = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        if (busy !== 1'b1) begin errors++; $display("FAIL t5_reaccept: busy=%b want 1", busy); end
        checks++;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (result !== {32'd2, 32'd8}) begin
            errors++; $display("FAIL t5_new_result: got %h want %h", result, {32'd2, 32'd8});
        end
        checks++;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_bpc4();
        logic [31:0] q, r; logic dz, dzA; int edges, busyCycles;
        sel = 1;
        doOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, dzA, edges, busyCycles);
        if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
            errors++; $display("FAIL t6_overflow: got Q=%h R=%h dz=%b want 80000000 0 0", q, r, dz);
        end
        checks++;
        if (edges !== 8) begin errors++; $display("FAIL t6_latency: ready after %0d edges want 8", edges); end
        checks++;
        doOp(1'b0, 32'd5, 32'd0, q, r, dz, dzA, edges, busyCycles);
        if (edges !== 1 || dz !== 1'b1 || {r, q} !== 64'd0) begin
            errors++; $display("FAIL t6_divzero: edges=%0d dz=%b result=%h want 1 1 0", edges, dz, {r, q});
        end
        checks++;
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er; logic dz, dzA, edz; bit sg;
        int edges, busyCycles, expEdges, nOps;
        for (int s = 0; s < 2; s++) begin
            sel  = s;
            nOps = (s == 0) ? 600 : 2500;
            for (int n = 0; n < nOps; n++) begin
                sg = 1'($urandom_range(0, 1));
                a  = randOperand();
                b  = randOperand();
                refModel(sg, a, b, eq, er, edz);
                expEdges = edz ? 1 : ((s == 0) ? 32 : 8);
                doOp(sg, a, b, q, r, dz, dzA, edges, busyCycles);
                if (q !== eq || r !== er || dz !== edz || edges !== expEdges) begin
                    errors++;
                    $display("FAIL rand_bpc%0d_op%0d: %s %h/%h got Q=%h R=%h dz=%b lat=%0d want Q=%h R=%h dz=%b lat=%0d",
                             (s == 0) ? 1 : 4, n, sg ? "signed" : "unsigned", a, b, q, r, dz, edges, eq, er, edz, expEdges);
                end
                checks++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_hold();
        test_bpc4();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
